// File: rtl/lighting_mode_ctrl.sv
// -----------------------------------------------------------------------------
// lighting_mode_ctrl
//
// Purpose:
//   Lamp mode controller between the push-button decoder and the lamp driver.
//   In automatic mode the lamp follows the presence sensor, with a hold-off
//   period after presence drops. In manual mode short presses toggle the lamp,
//   and an inactivity timeout returns the controller to automatic mode.
//
// Parameters:
//   HOLD_T            cycles the lamp stays on in auto mode after presence drops
//   MANUAL_TIMEOUT_T  cycles without a short press before manual reverts to auto
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   short_press    in   one-cycle pulse, toggles lamp in manual mode
//   long_press     in   one-cycle pulse, toggles auto/manual mode
//   presence       in   presence level, synchronous to clk
//   daylight       in   (only with LIGHT_CTRL_DAYLIGHT_EN) daylight level
//   lamp           out  lamp enable, registered
//   manual         out  high while in manual mode, registered
//   timeout_pulse  out  one-cycle pulse when manual mode times out, registered
//   state_o        out  current state encoding (debug)
//
// Configuration macro:
//   LIGHT_CTRL_DAYLIGHT_EN  adds the daylight input; daylight suppresses the
//                           lamp in auto mode. Undefined: behaves as daylight=0.
// -----------------------------------------------------------------------------
module lighting_mode_ctrl #(
    parameter int HOLD_T           = 30000,
    parameter int MANUAL_TIMEOUT_T = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       short_press,
    input  logic       long_press,
    input  logic       presence,
`ifdef LIGHT_CTRL_DAYLIGHT_EN
    input  logic       daylight,
`endif
    output logic       lamp,
    output logic       manual,
    output logic       timeout_pulse,
    output logic [2:0] state_o
);

    localparam int MAX_T = (HOLD_T > MANUAL_TIMEOUT_T) ? HOLD_T : MANUAL_TIMEOUT_T;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_T - 1);
    localparam logic [CW-1:0] MAN_LAST  = CW'(MANUAL_TIMEOUT_T - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        AUTO_IDLE  = 3'd0,
        AUTO_ON    = 3'd1,
        AUTO_HOLD  = 3'd2,
        MANUAL_OFF = 3'd3,
        MANUAL_ON  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]   man_cnt_q, man_cnt_d;
    logic            lamp_q, manual_q, tmo_q, tmo_d;
    logic            day_w;

`ifdef LIGHT_CTRL_DAYLIGHT_EN
    assign day_w = daylight;
`else
    assign day_w = 1'b0;
`endif

    function automatic logic lamp_of(input state_t s);
        return (s == AUTO_ON) || (s == AUTO_HOLD) || (s == MANUAL_ON);
    endfunction

    function automatic logic manual_of(input state_t s);
        return (s == MANUAL_OFF) || (s == MANUAL_ON);
    endfunction

    // Leaving manual mode (long press or timeout) lands on the auto state
    // matching the current presence level.
    function automatic state_t auto_entry(input logic pres);
        return pres ? AUTO_ON : AUTO_IDLE;
    endfunction

    // Next-state and counter logic. Counters default to 0 so that any state
    // not actively counting holds them cleared.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        man_cnt_d  = '0;
        tmo_d      = 1'b0;
        case (state_q)
            AUTO_IDLE: begin
                if (long_press)
                    state_d = MANUAL_OFF;
                else if (presence && !day_w)
                    state_d = AUTO_ON;
            end
            AUTO_ON: begin
                if (long_press)
                    state_d = MANUAL_ON;
                else if (day_w)
                    state_d = AUTO_IDLE;
                else if (!presence)
                    state_d = AUTO_HOLD;
            end
            AUTO_HOLD: begin
                if (long_press)
                    state_d = MANUAL_ON;
                else if (day_w)
                    state_d = AUTO_IDLE;
                else if (presence)
                    state_d = AUTO_ON;
                else if (hold_cnt_q == HOLD_LAST)
                    state_d = AUTO_IDLE;
                else
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
            MANUAL_OFF, MANUAL_ON: begin
                // A short press on the terminal count restarts the timeout,
                // so it is tested before the timeout itself.
                if (long_press)
                    state_d = auto_entry(presence);
                else if (short_press)
                    state_d = (state_q == MANUAL_OFF) ? MANUAL_ON : MANUAL_OFF;
                else if (man_cnt_q == MAN_LAST) begin
                    state_d = auto_entry(presence);
                    tmo_d   = 1'b1;
                end else
                    man_cnt_d = man_cnt_q + CNT_ONE;
            end
            default: state_d = AUTO_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= AUTO_IDLE;
            hold_cnt_q <= '0;
            man_cnt_q  <= '0;
            lamp_q     <= 1'b0;
            manual_q   <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            man_cnt_q  <= man_cnt_d;
            lamp_q     <= lamp_of(state_d);
            manual_q   <= manual_of(state_d);
            tmo_q      <= tmo_d;
        end
    end

    assign lamp          = lamp_q;
    assign manual        = manual_q;
    assign timeout_pulse = tmo_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_lighting_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lighting_mode_ctrl
//
// Directed bench for lighting_mode_ctrl with HOLD_T=4, MANUAL_TIMEOUT_T=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the rising edge that should have produced them. Expected values
// are written as {state, lamp, manual, timeout_pulse} per step.
// Build with LIGHT_CTRL_DAYLIGHT_EN to include the daylight scenarios.
// -----------------------------------------------------------------------------
module tb_lighting_mode_ctrl;

    localparam int HOLD_T = 4;
    localparam int MT     = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ON   = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_MOFF = 3'd3;
    localparam logic [2:0] S_MON  = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       short_press = 1'b0;
    logic       long_press = 1'b0;
    logic       presence = 1'b0;
`ifdef LIGHT_CTRL_DAYLIGHT_EN
    logic       daylight = 1'b0;
`endif
    logic       lamp, manual, timeout_pulse;
    logic [2:0] state_o;

    int n_run  = 0;
    int n_fail = 0;

    lighting_mode_ctrl #(
        .HOLD_T(HOLD_T),
        .MANUAL_TIMEOUT_T(MT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .short_press(short_press),
        .long_press(long_press),
        .presence(presence),
`ifdef LIGHT_CTRL_DAYLIGHT_EN
        .daylight(daylight),
`endif
        .lamp(lamp),
        .manual(manual),
        .timeout_pulse(timeout_pulse),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] st,
                       input logic l, input logic m, input logic t);
        logic [5:0] obs, exp;
        obs = {state_o, lamp, manual, timeout_pulse};
        exp = {st, l, m, t};
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed state=%0d lamp=%b manual=%b tmo=%b, expected state=%0d lamp=%b manual=%b tmo=%b",
                   tag, obs[5:3], obs[2], obs[1], obs[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One-cycle press pulses, sampled at the next rising edge.
    task automatic press(input logic lp, input logic sp);
        long_press  = lp;
        short_press = sp;
        tick();
        long_press  = 1'b0;
        short_press = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", S_IDLE, 0, 0, 0);
        tick();
        chk("idle_no_presence", S_IDLE, 0, 0, 0);

        // ---------------- hold ----------------
        presence = 1'b1;
        tick();
        chk("hold_rise", S_ON, 1, 0, 0);
        tick();
        chk("hold_on2", S_ON, 1, 0, 0);
        tick();
        chk("hold_on3", S_ON, 1, 0, 0);
        presence = 1'b0;
        for (int i = 0; i < HOLD_T; i++) begin
            tick();
            chk($sformatf("hold_cycle%0d", i), S_HOLD, 1, 0, 0);
        end
        tick();
        chk("hold_expire", S_IDLE, 0, 0, 0);

        // hold interrupted by presence in the third hold cycle
        presence = 1'b1;
        tick();
        chk("rehold_rise", S_ON, 1, 0, 0);
        presence = 1'b0;
        tick();
        chk("rehold_h1", S_HOLD, 1, 0, 0);
        tick();
        chk("rehold_h2", S_HOLD, 1, 0, 0);
        tick();
        chk("rehold_h3", S_HOLD, 1, 0, 0);
        presence = 1'b1;
        tick();
        chk("rehold_back_on", S_ON, 1, 0, 0);

        // ---------------- manual toggle ----------------
        press(1, 0);
        chk("man_enter_on", S_MON, 1, 1, 0);
        press(0, 1);
        chk("man_toggle_off", S_MOFF, 0, 1, 0);
        press(0, 1);
        chk("man_toggle_on", S_MON, 1, 1, 0);
        presence = 1'b0;
        press(1, 0);
        chk("man_exit_idle", S_IDLE, 0, 0, 0);

        // ---------------- timeout ----------------
        press(1, 0);
        chk("tmo_enter_off", S_MOFF, 0, 1, 0);
        for (int i = 1; i < MT; i++) begin
            tick();
            chk($sformatf("tmo_wait%0d", i), S_MOFF, 0, 1, 0);
        end
        tick();
        chk("tmo_fire", S_IDLE, 0, 0, 1);
        tick();
        chk("tmo_pulse_end", S_IDLE, 0, 0, 0);

        // short press on the terminal cycle suppresses the timeout
        press(1, 0);
        chk("tmo2_enter_off", S_MOFF, 0, 1, 0);
        for (int i = 1; i < MT; i++) tick();
        chk("tmo2_before_press", S_MOFF, 0, 1, 0);
        press(0, 1);
        chk("tmo2_press_on", S_MON, 1, 1, 0);
        presence = 1'b1;
        for (int i = 1; i < MT; i++) begin
            tick();
            chk($sformatf("tmo2_wait%0d", i), S_MON, 1, 1, 0);
        end
        tick();
        chk("tmo2_fire_auto_on", S_ON, 1, 0, 1);
        presence = 1'b0;
        tick();
        chk("tmo2_to_hold", S_HOLD, 1, 0, 0);
        for (int i = 1; i < HOLD_T; i++) tick();
        tick();
        chk("tmo2_hold_done", S_IDLE, 0, 0, 0);

        // ---------------- collisions ----------------
        press(1, 0);
        chk("col_enter_off", S_MOFF, 0, 1, 0);
        press(1, 1);
        chk("col_long_short", S_IDLE, 0, 0, 0);

        press(1, 0);
        for (int i = 1; i < MT; i++) tick();
        chk("col_tmo_pre", S_MOFF, 0, 1, 0);
        press(1, 0);
        chk("col_long_on_tmo", S_IDLE, 0, 0, 0);

        press(0, 1);
        chk("col_short_auto", S_IDLE, 0, 0, 0);

        // ---------------- asynchronous reset mid AUTO_ON ----------------
        presence = 1'b1;
        tick();
        chk("rst_pre_on", S_ON, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async", S_IDLE, 0, 0, 0);
        presence = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_release1", S_IDLE, 0, 0, 0);
        tick();
        chk("rst_release2", S_IDLE, 0, 0, 0);

`ifdef LIGHT_CTRL_DAYLIGHT_EN
        // ---------------- daylight ----------------
        daylight = 1'b1;
        presence = 1'b1;
        tick();
        chk("day_idle_blocks", S_IDLE, 0, 0, 0);
        daylight = 1'b0;
        tick();
        chk("day_clear_on", S_ON, 1, 0, 0);
        presence = 1'b0;
        tick();
        chk("day_hold", S_HOLD, 1, 0, 0);
        daylight = 1'b1;
        tick();
        chk("day_hold_to_idle", S_IDLE, 0, 0, 0);
        daylight = 1'b0;
        press(1, 0);
        chk("day_man_off", S_MOFF, 0, 1, 0);
        press(0, 1);
        chk("day_man_on", S_MON, 1, 1, 0);
        daylight = 1'b1;
        tick();
        chk("day_man_unaffected", S_MON, 1, 1, 0);
        daylight = 1'b0;
        press(1, 0);
        chk("day_man_exit", S_IDLE, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
